// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between mem_port_arbiter, its two requesters (core and
// program loader/debug port) and the unified instruction/data memory.
//   c_*   : core request (req/we/addr/wdata/be in; gnt/rvalid/rdata out)
//   l_*   : loader request, same shape as core, plus l_lock priority hold
//   mem_* : memory strobes and registered address/data/byte enables out,
//           mem_rdata in
// Modport slave is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W/8-1:0] c_be;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [DATA_W/8-1:0] l_be;
  logic              l_lock;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_be,
    input  l_req, l_we, l_addr, l_wdata, l_be, l_lock,
    input  mem_rdata,
    output c_gnt, c_rvalid, c_rdata,
    output l_gnt, l_rvalid, l_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_be,
    output l_req, l_we, l_addr, l_wdata, l_be, l_lock,
    output mem_rdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory of the multicycle RV32I core between
// the core and the program loader/debug port. One transaction at a time:
// IDLE (grant) -> ACCESS (mem_en strobe) -> [WAIT (read latency)] -> IDLE.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave -- core/loader request bundles with
//          gnt/rvalid/rdata returns, and the memory-side strobes/data.
// Parameters: ADDR_W, DATA_W (multiple of 8), MEM_LAT (>=1) cycles from the
// mem_en cycle to the cycle mem_rdata is valid.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_dw
    $error("mem_port_arbiter: DATA_W must be a multiple of 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;
  typedef enum logic {OWN_CORE, OWN_LOADER} owner_t;

  state_t            state, state_nx;
  owner_t            owner, last_grant;
  logic              we_q;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              c_win, l_win, rd_done;

  // Grants and the read-complete strobe are suppressed while rst is high so
  // nothing is handed out in a cycle whose register updates are discarded.
  always_comb begin
    state_nx = state;
    c_win    = 1'b0;
    l_win    = 1'b0;
    rd_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rst) begin
          l_win = bus.l_req && (bus.l_lock || !bus.c_req || last_grant == OWN_CORE);
          c_win = bus.c_req && !l_win;
          if (l_win || c_win) state_nx = S_ACCESS;
        end
      end
      S_ACCESS: state_nx = we_q ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          rd_done  = !rst;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_CORE;
      last_grant <= OWN_LOADER;
      we_q       <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      state <= state_nx;
      if (l_win) begin
        owner      <= OWN_LOADER;
        last_grant <= OWN_LOADER;
        we_q       <= bus.l_we;
        addr_q     <= bus.l_addr;
        wdata_q    <= bus.l_wdata;
        be_q       <= bus.l_be;
      end else if (c_win) begin
        owner      <= OWN_CORE;
        last_grant <= OWN_CORE;
        we_q       <= bus.c_we;
        addr_q     <= bus.c_addr;
        wdata_q    <= bus.c_wdata;
        be_q       <= bus.c_be;
      end
      if (state == S_ACCESS) cnt <= CNT_W'(MEM_LAT);
      else if (state == S_WAIT) cnt <= cnt - 1'b1;
    end
  end

  logic c_rv, l_rv;
  assign c_rv = rd_done && (owner == OWN_CORE);
  assign l_rv = rd_done && (owner == OWN_LOADER);

  assign bus.c_gnt     = c_win;
  assign bus.l_gnt     = l_win;
  assign bus.c_rvalid  = c_rv;
  assign bus.l_rvalid  = l_rv;
  assign bus.c_rdata   = c_rv ? bus.mem_rdata : '0;
  assign bus.l_rdata   = l_rv ? bus.mem_rdata : '0;
  assign bus.mem_en    = (state == S_ACCESS);
  assign bus.mem_we    = (state == S_ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    b2.c_req = 0; b2.c_we = 0; b2.c_addr = '0; b2.c_wdata = '0; b2.c_be = '0;
    b2.l_req = 0; b2.l_we = 0; b2.l_addr = '0; b2.l_wdata = '0; b2.l_be = '0;
    b2.l_lock = 0; b2.mem_rdata = '0;
    b1.c_req = 0; b1.c_we = 0; b1.c_addr = '0; b1.c_wdata = '0; b1.c_be = '0;
    b1.l_req = 0; b1.l_we = 0; b1.l_addr = '0; b1.l_wdata = '0; b1.l_be = '0;
    b1.l_lock = 0; b1.mem_rdata = '0;
  endtask

  task automatic do_reset;
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset;
    logic [5:0] obs;
    clear_inputs();
    rst = 1;
    b2.c_req = 1; b2.l_req = 1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    obs = {b2.c_gnt, b2.l_gnt, b2.c_rvalid, b2.l_rvalid, b2.mem_en, b2.mem_we};
    vectors++;
    if (obs !== 6'b0) begin miscompares++; $display("FAIL reset_ctl: got %b expected 000000", obs); end
    vectors++;
    if ({b2.mem_addr, b2.mem_wdata, b2.mem_be} !== '0) begin
      miscompares++; $display("FAIL reset_regs: got %h/%h/%h expected 0", b2.mem_addr, b2.mem_wdata, b2.mem_be);
    end
    vectors++;
    if ({b1.mem_en, b1.c_gnt, b1.l_gnt} !== 3'b0) begin
      miscompares++; $display("FAIL reset_lat1: got %b expected 000", {b1.mem_en, b1.c_gnt, b1.l_gnt});
    end
    next_cycle();
    rst = 0;
    b2.c_req = 0; b2.l_req = 0;
  endtask

  task automatic test_core_read;
    b2.c_req = 1; b2.c_we = 0; b2.c_addr = 32'h0000_0010; b2.c_be = 4'hF;
    @(negedge clk);
    vectors++;
    if ({b2.c_gnt, b2.l_gnt, b2.l_rvalid} !== 3'b100) begin
      miscompares++; $display("FAIL rd_gnt: got %b expected 100", {b2.c_gnt, b2.l_gnt, b2.l_rvalid});
    end
    next_cycle();
    b2.c_req = 0;
    @(negedge clk);
    vectors++;
    if ({b2.mem_en, b2.mem_we, b2.c_gnt, b2.c_rvalid, b2.l_rvalid} !== 5'b10000) begin
      miscompares++; $display("FAIL rd_access: got %b expected 10000", {b2.mem_en, b2.mem_we, b2.c_gnt, b2.c_rvalid, b2.l_rvalid});
    end
    vectors++;
    if (b2.mem_addr !== 32'h10) begin miscompares++; $display("FAIL rd_addr: got %h expected 00000010", b2.mem_addr); end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({b2.mem_en, b2.c_rvalid, b2.l_rvalid} !== 3'b000) begin
      miscompares++; $display("FAIL rd_wait: got %b expected 000", {b2.mem_en, b2.c_rvalid, b2.l_rvalid});
    end
    next_cycle();
    b2.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if ({b2.c_rvalid, b2.l_rvalid} !== 2'b10) begin
      miscompares++; $display("FAIL rd_valid: got %b expected 10", {b2.c_rvalid, b2.l_rvalid});
    end
    vectors++;
    if (b2.c_rdata !== 32'hDEAD_BEEF || b2.l_rdata !== 32'h0) begin
      miscompares++; $display("FAIL rd_data: got %h/%h expected deadbeef/00000000", b2.c_rdata, b2.l_rdata);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({b2.c_rvalid, b2.c_rdata} !== 33'h0) begin
      miscompares++; $display("FAIL rd_after: got %b/%h expected 0/00000000", b2.c_rvalid, b2.c_rdata);
    end
    b2.mem_rdata = '0;
    next_cycle();
  endtask

  task automatic test_core_write;
    b2.c_req = 1; b2.c_we = 1; b2.c_addr = 32'h20; b2.c_wdata = 32'h1234_5678; b2.c_be = 4'b0011;
    @(negedge clk);
    vectors++;
    if (b2.c_gnt !== 1'b1) begin miscompares++; $display("FAIL wr_gnt: got %b expected 1", b2.c_gnt); end
    next_cycle();
    b2.c_req = 0; b2.c_we = 0;
    b2.l_req = 1; b2.l_we = 0; b2.l_addr = 32'h30;
    @(negedge clk);
    vectors++;
    if ({b2.mem_en, b2.mem_we, b2.c_rvalid, b2.l_gnt} !== 4'b1100) begin
      miscompares++; $display("FAIL wr_access: got %b expected 1100", {b2.mem_en, b2.mem_we, b2.c_rvalid, b2.l_gnt});
    end
    vectors++;
    if (b2.mem_addr !== 32'h20 || b2.mem_wdata !== 32'h1234_5678 || b2.mem_be !== 4'b0011) begin
      miscompares++; $display("FAIL wr_bus: got %h/%h/%b expected 00000020/12345678/0011", b2.mem_addr, b2.mem_wdata, b2.mem_be);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({b2.l_gnt, b2.c_gnt, b2.c_rvalid, b2.mem_en} !== 4'b1000) begin
      miscompares++; $display("FAIL wr_idle_next: got %b expected 1000", {b2.l_gnt, b2.c_gnt, b2.c_rvalid, b2.mem_en});
    end
    next_cycle();
    b2.l_req = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if (b2.l_rvalid !== 1'b1) begin miscompares++; $display("FAIL wr_then_lrd: got %b expected 1", b2.l_rvalid); end
    next_cycle();
  endtask

  task automatic test_round_robin;
    logic [3:0] obs, exp;
    logic [31:0] exp_c, exp_l;
    do_reset();
    b2.c_req = 1; b2.c_we = 0; b2.l_req = 1; b2.l_we = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc > 0) next_cycle();
      b2.mem_rdata = 32'hC0DE_0000 + 32'(cyc);
      @(negedge clk);
      exp = {cyc % 8 == 0, cyc % 8 == 4, cyc % 8 == 3, cyc % 8 == 7};
      exp_c = exp[1] ? 32'hC0DE_0000 + 32'(cyc) : 32'h0;
      exp_l = exp[0] ? 32'hC0DE_0000 + 32'(cyc) : 32'h0;
      obs = {b2.c_gnt, b2.l_gnt, b2.c_rvalid, b2.l_rvalid};
      vectors++;
      if (obs !== exp) begin
        miscompares++; $display("FAIL rr_cyc%0d: got %b expected %b", cyc, obs, exp);
      end
      if (exp[1] || exp[0]) begin
        vectors++;
        if (b2.c_rdata !== exp_c || b2.l_rdata !== exp_l) begin
          miscompares++; $display("FAIL rr_data_cyc%0d: got %h/%h expected %h/%h", cyc, b2.c_rdata, b2.l_rdata, exp_c, exp_l);
        end
      end
    end
    next_cycle();
    b2.c_req = 0; b2.l_req = 0; b2.mem_rdata = '0;
  endtask

  task automatic test_lock;
    logic [1:0] obs, exp;
    b2.l_lock = 1; b2.c_req = 1; b2.l_req = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) next_cycle();
      @(negedge clk);
      exp = {1'b0, cyc % 4 == 0};
      obs = {b2.c_gnt, b2.l_gnt};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL lock_cyc%0d: got %b expected %b", cyc, obs, exp); end
    end
    next_cycle();
    b2.l_lock = 0;
    @(negedge clk);
    vectors++;
    if ({b2.c_gnt, b2.l_gnt} !== 2'b10) begin
      miscompares++; $display("FAIL unlock_gnt: got %b expected 10", {b2.c_gnt, b2.l_gnt});
    end
    next_cycle();
    b2.c_req = 0; b2.l_req = 0;
    next_cycle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_lock_no_req;
    b2.l_lock = 1; b2.c_req = 1; b2.l_req = 0;
    @(negedge clk);
    vectors++;
    if ({b2.c_gnt, b2.l_gnt} !== 2'b10) begin
      miscompares++; $display("FAIL lock_noreq: got %b expected 10", {b2.c_gnt, b2.l_gnt});
    end
    next_cycle();
    b2.c_req = 0; b2.l_lock = 0;
    next_cycle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_in_wait;
    logic [5:0] obs;
    b2.l_req = 1; b2.l_we = 0; b2.l_addr = 32'h44;
    @(negedge clk);
    vectors++;
    if (b2.l_gnt !== 1'b1) begin miscompares++; $display("FAIL rw_gnt: got %b expected 1", b2.l_gnt); end
    next_cycle();
    b2.l_req = 0;
    next_cycle();
    rst = 1;
    b2.mem_rdata = 32'hBAD0_0001;
    @(negedge clk);
    vectors++;
    if (b2.l_rvalid !== 1'b0) begin miscompares++; $display("FAIL rw_wait_rv: got %b expected 0", b2.l_rvalid); end
    next_cycle();
    rst = 0;
    @(negedge clk);
    obs = {b2.c_gnt, b2.l_gnt, b2.c_rvalid, b2.l_rvalid, b2.mem_en, b2.mem_we};
    vectors++;
    if (obs !== 6'b0 || b2.l_rdata !== 32'h0) begin
      miscompares++; $display("FAIL rw_after_rst: got %b/%h expected 000000/00000000", obs, b2.l_rdata);
    end
    vectors++;
    if (b2.mem_addr !== 32'h0) begin miscompares++; $display("FAIL rw_addr: got %h expected 00000000", b2.mem_addr); end
    next_cycle();
    b2.mem_rdata = '0;
    b2.c_req = 1; b2.l_req = 1;
    @(negedge clk);
    vectors++;
    if ({b2.c_gnt, b2.l_gnt, b2.l_rvalid} !== 3'b100) begin
      miscompares++; $display("FAIL rw_first_gnt: got %b expected 100", {b2.c_gnt, b2.l_gnt, b2.l_rvalid});
    end
    next_cycle();
    b2.c_req = 0; b2.l_req = 0;
    next_cycle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_back_to_back;
    logic [2:0] obs, exp;
    b1.c_req = 1; b1.c_we = 0; b1.c_addr = 32'h80;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc > 0) next_cycle();
      b1.mem_rdata = 32'h1111_0000 + 32'(cyc);
      @(negedge clk);
      exp = {cyc % 3 == 0, cyc % 3 == 1, cyc % 3 == 2};
      obs = {b1.c_gnt, b1.mem_en, b1.c_rvalid};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL b2b_cyc%0d: got %b expected %b", cyc, obs, exp); end
      if (exp[0]) begin
        vectors++;
        if (b1.c_rdata !== 32'h1111_0000 + 32'(cyc)) begin
          miscompares++; $display("FAIL b2b_data_cyc%0d: got %h expected %h", cyc, b1.c_rdata, 32'h1111_0000 + 32'(cyc));
        end
      end
    end
    next_cycle();
    b1.c_req = 0; b1.mem_rdata = '0;
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_core_write();
    test_round_robin();
    test_lock();
    test_lock_no_req();
    test_reset_in_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
